// File: rtl/hazard_forward_scoreboard.sv
// rtl/hazard_forward_scoreboard.sv - parametrised ID/EX hazard stall and forwarding-select controller
module hazard_forward_scoreboard #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 4,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic [REG_W-1:0]         id_rd,
    input  logic                     id_regwrite,
    input  logic [SEL_W-1:0]         id_lat,
    input  logic                     pipe_hold,
    input  logic                     flush,
    output logic                     stall,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic [CNT_W-1:0]         stall_count
);

    // h_*[0] describes the writer now in EX; h_*[k] is k stages further down.
    logic             h_valid [DEPTH];
    logic [REG_W-1:0] h_rd    [DEPTH];
    logic [SEL_W-1:0] h_lat   [DEPTH];

    logic [NUM_SRC*SEL_W-1:0] sel_comb;
    logic [NUM_SRC-1:0]       src_stall;
    logic [SEL_W-1:0]         lat_norm;

    always_comb begin
        lat_norm = id_lat;
        if (id_lat == '0)
            lat_norm = SEL_W'(1);
        else if (id_lat > SEL_W'(DEPTH))
            lat_norm = SEL_W'(DEPTH);
    end

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [REG_W-1:0] rs;
        logic             qual;
        logic [SEL_W-1:0] sel;
        logic             st;

        assign rs   = id_rs[s*REG_W +: REG_W];
        assign qual = id_valid & id_rs_used[s] & (rs != '0);

        // Scan oldest to youngest so the youngest matching writer overrides.
        always_comb begin
            sel = '0;
            st  = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (qual && h_valid[k] && (h_rd[k] == rs)) begin
                    sel = SEL_W'(k + 1);
                    st  = (SEL_W'(k + 1) < h_lat[k]);
                end
            end
        end

        assign sel_comb[s*SEL_W +: SEL_W] = sel;
        assign src_stall[s]               = st;
    end

    assign stall = id_valid & ~flush & (|src_stall);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                h_valid[k] <= 1'b0;
                h_rd[k]    <= '0;
                h_lat[k]   <= '0;
            end
            fwd_sel     <= '0;
            stall_count <= '0;
        end else if (!pipe_hold) begin
            // The oldest entry falls off: its writer has reached the write-first regfile.
            for (int k = DEPTH - 1; k > 0; k--) begin
                h_valid[k] <= h_valid[k-1];
                h_rd[k]    <= h_rd[k-1];
                h_lat[k]   <= h_lat[k-1];
            end
            h_valid[0] <= id_valid & id_regwrite & (id_rd != '0) & ~stall & ~flush;
            h_rd[0]    <= id_rd;
            h_lat[0]   <= lat_norm;
            fwd_sel    <= (stall | flush | ~id_valid) ? '0 : sel_comb;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// tb/tb_hazard_forward_scoreboard.sv - directed and random checks of hazard_forward_scoreboard against an age-queue model
module tb_hazard_forward_scoreboard;

    localparam int REG_W = 5;
    localparam int NSRC  = 2;
    localparam int DEPTH = 4;
    localparam int SEL_W = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    id_valid;
    logic [NSRC*REG_W-1:0]   id_rs;
    logic [NSRC-1:0]         id_rs_used;
    logic [REG_W-1:0]        id_rd;
    logic                    id_regwrite;
    logic [SEL_W-1:0]        id_lat;
    logic                    pipe_hold;
    logic                    flush;
    logic                    stall, stall_b;
    logic [NSRC*SEL_W-1:0]   fwd_sel, fwd_sel_b;
    logic [15:0]             stall_count;
    logic [3:0]              stall_count_b;

    always #5 clk = ~clk;

    hazard_forward_scoreboard u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_lat(id_lat), .pipe_hold(pipe_hold), .flush(flush),
        .stall(stall), .fwd_sel(fwd_sel), .stall_count(stall_count)
    );

    // Narrow counter copy so saturation is reached quickly.
    hazard_forward_scoreboard #(.CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_lat(id_lat), .pipe_hold(pipe_hold), .flush(flush),
        .stall(stall_b), .fwd_sel(fwd_sel_b), .stall_count(stall_count_b)
    );

    typedef struct {
        int rd;
        int lat;
        int age;
    } wr_t;

    wr_t        infl[$];
    int         m_sel[NSRC];
    bit         m_stall;
    logic [5:0] exp_fwd = '0;
    int         exp_cnt = 0;
    int         exp_cnt_b = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       last_stall;
    logic [5:0] last_sel;
    logic [15:0] last_cnt;
    int         c0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_eval();
        bit any;
        int rs;
        int best;
        int blat;
        any = 0;
        for (int s = 0; s < NSRC; s++) begin
            rs = int'(id_rs[s*REG_W +: REG_W]);
            best = -1;
            blat = 0;
            m_sel[s] = 0;
            if (id_valid && id_rs_used[s] && rs != 0) begin
                foreach (infl[i])
                    if (infl[i].rd == rs && (best < 0 || infl[i].age < best)) begin
                        best = infl[i].age;
                        blat = infl[i].lat;
                    end
            end
            if (best >= 0) begin
                m_sel[s] = best + 1;
                if (best + 1 < blat) any = 1;
            end
        end
        m_stall = id_valid && !flush && any;
    endfunction

    function automatic void model_edge();
        wr_t nq[$];
        wr_t w;
        int  lat;
        if (reset) begin
            infl.delete();
            exp_fwd = '0;
            exp_cnt = 0;
            exp_cnt_b = 0;
        end else if (!pipe_hold) begin
            foreach (infl[i]) begin
                w = infl[i];
                w.age++;
                if (w.age < DEPTH) nq.push_back(w);
            end
            infl = nq;
            lat = int'(id_lat);
            if (lat == 0) lat = 1;
            if (lat > DEPTH) lat = DEPTH;
            if (id_valid && id_regwrite && id_rd != 0 && !m_stall && !flush) begin
                w.rd = int'(id_rd);
                w.lat = lat;
                w.age = 0;
                infl.push_back(w);
            end
            exp_fwd = (m_stall || flush || !id_valid) ? 6'd0 : {3'(m_sel[1]), 3'(m_sel[0])};
            if (m_stall) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt_b < 15) exp_cnt_b++;
            end
        end
    endfunction

    task automatic cycle();
        #3;
        model_eval();
        last_stall = stall;
        chk("stall", 32'(stall), 32'(m_stall));
        chk("stall_sat", 32'(stall_b), 32'(m_stall));
        model_edge();
        @(posedge clk);
        #1;
        last_sel = fwd_sel;
        last_cnt = stall_count;
        chk("fwd_sel", 32'(fwd_sel), 32'(exp_fwd));
        chk("fwd_sel_sat", 32'(fwd_sel_b), 32'(exp_fwd));
        chk("stall_count", 32'(stall_count), 32'(exp_cnt));
        chk("stall_count_sat", 32'(stall_count_b), 32'(exp_cnt_b));
    endtask

    task automatic drive(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                         input int rd, input bit rw, input int lat);
        id_valid    = v;
        id_rs       = {5'(rs1), 5'(rs0)};
        id_rs_used  = used;
        id_rd       = 5'(rd);
        id_regwrite = rw;
        id_lat      = 3'(lat);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 2'b00, 0, 0, 1);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b1;
        pipe_hold = 1'b0;
        flush = 1'b0;
        drive(0, 0, 0, 2'b00, 0, 0, 1);
        @(posedge clk);
        #1;
        cycle();
        chk("rst_stall", 32'(last_stall), 32'd0);
        chk("rst_sel", 32'(last_sel), 32'd0);
        chk("rst_cnt", 32'(last_cnt), 32'd0);
        reset = 1'b0;

        // ALU producer then consumer
        drive(1, 0, 0, 2'b00, 5, 1, 1); cycle();
        drive(1, 5, 3, 2'b11, 9, 1, 1); cycle();
        chk("alu_stall", 32'(last_stall), 32'd0);
        chk("alu_sel", 32'(last_sel), 32'h01);
        chk("alu_cnt", 32'(last_cnt), 32'd0);
        idle(4);

        // Load-use: one bubble, then forward from EX+2
        drive(1, 0, 0, 2'b00, 6, 1, 2); cycle();
        drive(1, 0, 6, 2'b10, 10, 1, 1); cycle();
        chk("lu_stall1", 32'(last_stall), 32'd1);
        cycle();
        chk("lu_stall2", 32'(last_stall), 32'd0);
        chk("lu_sel", 32'(last_sel), 32'h10);
        chk("lu_cnt", 32'(last_cnt), 32'd1);
        idle(4);

        // Youngest writer wins; x0 never forwards
        drive(1, 0, 0, 2'b00, 7, 1, 1); cycle();
        drive(1, 0, 0, 2'b00, 7, 1, 1); cycle();
        drive(1, 7, 0, 2'b01, 11, 1, 1); cycle();
        chk("young_sel", 32'(last_sel), 32'h01);
        drive(1, 0, 0, 2'b00, 0, 1, 1); cycle();
        drive(1, 0, 0, 2'b01, 11, 1, 1); cycle();
        chk("x0_stall", 32'(last_stall), 32'd0);
        chk("x0_sel", 32'(last_sel), 32'h00);
        idle(4);

        // Latency-4 producer with a one-cycle hold mid-stall
        c0 = int'(last_cnt);
        drive(1, 0, 0, 2'b00, 8, 1, 4); cycle();
        drive(1, 8, 0, 2'b01, 12, 1, 1); cycle();
        chk("mul_stall1", 32'(last_stall), 32'd1);
        cycle();
        chk("mul_stall2", 32'(last_stall), 32'd1);
        pipe_hold = 1'b1; cycle(); pipe_hold = 1'b0;
        chk("mul_hold_stall", 32'(last_stall), 32'd1);
        chk("mul_hold_cnt", 32'(last_cnt), 32'(c0 + 2));
        cycle();
        chk("mul_stall3", 32'(last_stall), 32'd1);
        cycle();
        chk("mul_stall4", 32'(last_stall), 32'd0);
        chk("mul_sel", 32'(last_sel), 32'h04);
        chk("mul_cnt", 32'(last_cnt), 32'(c0 + 3));
        idle(4);

        // Flush during a load-use stall
        drive(1, 0, 0, 2'b00, 6, 1, 2); cycle();
        flush = 1'b1;
        drive(1, 6, 0, 2'b01, 13, 1, 1); cycle();
        flush = 1'b0;
        chk("flush_stall", 32'(last_stall), 32'd0);
        chk("flush_sel", 32'(last_sel), 32'h00);
        drive(1, 13, 0, 2'b01, 14, 1, 1); cycle();
        chk("flush_bubble_sel", 32'(last_sel), 32'h00);
        idle(4);

        // Reset in the middle of a multi-cycle stall
        drive(1, 0, 0, 2'b00, 8, 1, 4); cycle();
        drive(1, 8, 0, 2'b01, 12, 1, 1); cycle();
        chk("rm_stall", 32'(last_stall), 32'd1);
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rm_sel", 32'(last_sel), 32'h00);
        chk("rm_cnt", 32'(last_cnt), 32'd0);
        cycle();
        chk("rm_stall_after", 32'(last_stall), 32'd0);

        // Random traffic, including out-of-range latencies
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            pipe_hold = ($urandom_range(0, 99) < 10);
            flush     = ($urandom_range(0, 99) < 8);
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_forward_scoreboard.md
Name: hazard_forward_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order RISC-V pipeline.
- Generalises the fixed two-source, two-stage EX/MEM and MEM/WB forwarding check to NUM_SRC source operands and a DEPTH-deep history of in-flight writers.
- Each writer carries a per-instruction result latency, so loads and multi-cycle ops (mul) share one mechanism.
- Sits at the ID/EX boundary. Drives the combinational stall to PC/IF/ID and registered operand-mux selects into EX.

Parameters:
- REG_W, 5, register index width.
- NUM_SRC, 2, source operands per instruction.
- DEPTH, 4, post-ID stages tracked; the last one is the final stage before writeback. Must be ≥2.
- SEL_W, $clog2(DEPTH+1), width of one forward select; also the width of the latency field.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- id_valid, input, 1, ID holds a real instruction.
- id_rs, input, NUM_SRC*REG_W, packed source indices; src s is at [s*REG_W +: REG_W].
- id_rs_used, input, NUM_SRC, src s actually read.
- id_rd, input, REG_W, destination index.
- id_regwrite, input, 1, instruction writes id_rd.
- id_lat, input, SEL_W, result latency: the stage (EX+id_lat) whose pipeline register first holds the result (ALU=1, load=2, mul=N).
- pipe_hold, input, 1, global freeze (memory busy); no state change.
- flush, input, 1, kill the instruction in ID (branch taken).
- stall, output, 1, combinational; hold PC/IF/ID and insert an ID/EX bubble.
- fwd_sel, output, NUM_SRC*SEL_W, registered select per src for the instruction now in EX: 0 = register file, k = forward from the EX+k pipeline register.
- stall_count, output, CNT_W, saturating count of stall cycles.

Behaviour:
- History h[0..DEPTH-1], each entry {valid, rd, lat}. h[0] is the instruction in EX; h[k] is k stages later.
- Match for src s at h[k]:
  - id_valid, id_rs_used[s], and id_rs[s]!=0 are all true;
  - h[k].valid is set;
  - h[k].rd equals id_rs[s].
  - The youngest match (smallest k) wins. Older matches are ignored.
- Computed select for src s:
  - k+1 if the src has a winning match;
  - 0 if the src has no match, or does not qualify as a match.
- Per-source stall: a winning match exists with (k+1) < h[k].lat.
- stall = id_valid & ~flush & OR of the per-source stalls. It is valid during pipe_hold, but has no state effect while held.
- Latency normalisation at capture: id_lat of 0 is treated as 1; id_lat greater than DEPTH is clamped to DEPTH.
- Advance on each posedge with ~pipe_hold & ~reset:
  - h[k+1] <= h[k] for k=0..DEPTH-2; h[DEPTH-1] is discarded, because its writer has written back and the regfile is write-first.
  - h[0].valid <= id_valid & id_regwrite & (id_rd!=0) & ~stall & ~flush.
  - h[0].rd <= id_rd; h[0].lat <= normalised id_lat.
  - fwd_sel <= 0 if stall | flush | ~id_valid, else the computed selects.
- With pipe_hold=1: h, fwd_sel and stall_count all hold.
- flush has priority over stall: it forces stall=0 and inserts an invalid entry.
- stall_count increments when stall & ~pipe_hold. It saturates at all-ones and does not wrap.
- Reset takes priority over pipe_hold and flush. It clears all h[].valid, fwd_sel=0 and stall_count=0, and is effective the next cycle, even mid-stall.
- Destination x0 never creates an entry, so it never stalls or forwards.
- Stall cycles:
  - ALU producer followed directly by a consumer: 0 stalls, sel 1.
  - Load followed directly by a consumer: 1 stall, sel 2.
  - Latency-L producer followed directly by a consumer: L-1 stalls, sel L.

Test Plan:
- ALU forward: issue add x5 (lat1), then consumer with rs1=x5 -> stall=0; fwd_sel[src0]=1, fwd_sel[src1]=0 in EX; stall_count=0.
- Load-use: lw x6 (lat2), then consumer with rs2=x6 -> stall=1 for 1 cycle, stall_count=1; fwd_sel[src1]=2 when the consumer is in EX.
- Youngest wins: add x7 (lat1), add x7 (lat1), then consumer with rs1=x7 -> fwd_sel[src0]=1, not 2. Also write x0 (regwrite=1) then consumer with rs1=x0 -> stall=0, sel 0.
- Multi-cycle: mul x8 (lat4), then consumer with rs1=x8 -> 3 stall cycles; assert pipe_hold for 1 cycle mid-stall -> stall_count pauses (ends at 3) and the stall sequence stretches by 1; final fwd_sel[src0]=4.
- Flush/reset: flush during a load-use stall -> stall=0, bubble, fwd_sel=0; reset asserted mid-mul-stall -> next cycle stall=0, fwd_sel=0, stall_count=0.
- Saturation: hold a stalling condition past 2^CNT_W-1 cycles -> stall_count stays at 0xFFFF.
